// File: rtl/timer_bank_if.sv
// -----------------------------------------------------------------------------
// timer_bank_if
// Groups the timer bank's configuration, strobe and status signals.
//   master : drives PRESCALE, START, STOP, PERIODIC, LIMIT; observes
//            PULSE, BUSY, COUNT
//   slave  : the timer bank itself (mirror of master)
// Widths follow the CHANNELS / WIDTH / PRESCALE_W parameters. LIMIT and
// COUNT are packed with channel i at [i*WIDTH +: WIDTH].
// -----------------------------------------------------------------------------
interface timer_bank_if #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 21,
    parameter int PRESCALE_W = 8
);
    logic [PRESCALE_W-1:0]     PRESCALE;
    logic [CHANNELS-1:0]       START;
    logic [CHANNELS-1:0]       STOP;
    logic [CHANNELS-1:0]       PERIODIC;
    logic [CHANNELS*WIDTH-1:0] LIMIT;
    logic [CHANNELS-1:0]       PULSE;
    logic [CHANNELS-1:0]       BUSY;
    logic [CHANNELS*WIDTH-1:0] COUNT;

    modport master (
        output PRESCALE, START, STOP, PERIODIC, LIMIT,
        input  PULSE, BUSY, COUNT
    );

    modport slave (
        input  PRESCALE, START, STOP, PERIODIC, LIMIT,
        output PULSE, BUSY, COUNT
    );
endinterface

// File: rtl/timer_bank.sv
// -----------------------------------------------------------------------------
// timer_bank
// CHANNELS independent interval timers sharing one free-running prescaler.
// A channel armed by START counts prescaler ticks up to its latched limit,
// then emits a one-cycle PULSE and either idles (one-shot) or reloads
// (periodic).
// Ports:
//   CLK  - clock
//   RST  - synchronous active-high reset
//   CLR  - synchronous clear, same effect as RST
//   bus  - timer_bank_if.slave: PRESCALE, START, STOP, PERIODIC, LIMIT in;
//          PULSE, BUSY, COUNT out (all outputs registered)
// -----------------------------------------------------------------------------
module timer_bank #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 21,
    parameter int PRESCALE_W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CLR,
    timer_bank_if.slave  bus
);
    // One-hot style encoding so that 2'b00 / 2'b11 are detectably illegal.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b01,
        ST_COUNT = 2'b10
    } state_e;

    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tick_s;
    logic                  clear_s;

    state_e                state_q [CHANNELS];
    state_e                state_d [CHANNELS];
    logic [WIDTH-1:0]      cnt_q   [CHANNELS];
    logic [WIDTH-1:0]      cnt_d   [CHANNELS];
    logic [WIDTH-1:0]      lim_q   [CHANNELS];
    logic [WIDTH-1:0]      lim_d   [CHANNELS];
    logic [CHANNELS-1:0]   per_q, per_d;
    logic [CHANNELS-1:0]   pulse_q, pulse_d;
    logic [CHANNELS-1:0]   busy_q, busy_d;
    logic [CHANNELS-1:0]   tc_s;

    assign clear_s = RST | CLR;

    // Prescaler: >= comparison keeps a live decrease of PRESCALE from overrunning.
    always_comb begin
        tick_s = (pcnt_q >= bus.PRESCALE);
        if (tick_s) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic per channel; STOP beats START and terminal count.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            tc_s[i]    = tick_s && (cnt_q[i] == lim_q[i]);
            state_d[i] = ST_IDLE;
            case (state_q[i])
                ST_IDLE: begin
                    if (bus.START[i] && !bus.STOP[i]) begin
                        state_d[i] = ST_COUNT;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    if (bus.STOP[i]) begin
                        state_d[i] = ST_IDLE;
                    end else if (bus.START[i]) begin
                        state_d[i] = ST_COUNT;
                    end else if (tc_s[i] && !per_q[i]) begin
                        state_d[i] = ST_IDLE;
                    end else begin
                        state_d[i] = ST_COUNT;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    // Output/datapath logic: counter, latched config, pulse and busy.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]   = cnt_q[i];
            lim_d[i]   = lim_q[i];
            per_d[i]   = per_q[i];
            pulse_d[i] = 1'b0;
            case (state_q[i])
                ST_IDLE: begin
                    cnt_d[i] = '0;
                    if (bus.START[i] && !bus.STOP[i]) begin
                        lim_d[i] = bus.LIMIT[i*WIDTH +: WIDTH];
                        per_d[i] = bus.PERIODIC[i];
                    end else begin
                        lim_d[i] = lim_q[i];
                    end
                end
                ST_COUNT: begin
                    if (bus.STOP[i]) begin
                        cnt_d[i] = '0;
                    end else if (bus.START[i]) begin
                        // Restart: the tick coinciding with START is not counted.
                        cnt_d[i] = '0;
                        lim_d[i] = bus.LIMIT[i*WIDTH +: WIDTH];
                        per_d[i] = bus.PERIODIC[i];
                    end else if (tc_s[i]) begin
                        pulse_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else if (tick_s) begin
                        cnt_d[i] = cnt_q[i] + {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d[i] = cnt_q[i];
                    end
                end
                default: cnt_d[i] = '0;
            endcase
            busy_d[i] = (state_d[i] == ST_COUNT);
        end
    end

    // State register for all channel FSMs.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (clear_s) begin
                state_q[i] <= ST_IDLE;
            end else begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Datapath registers: prescaler, counters, latched config and outputs.
    always_ff @(posedge CLK) begin
        if (clear_s) begin
            pcnt_q  <= '0;
            per_q   <= '0;
            pulse_q <= '0;
            busy_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
                lim_q[i] <= '0;
            end
        end else begin
            pcnt_q  <= pcnt_d;
            per_q   <= per_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
                lim_q[i] <= lim_d[i];
            end
        end
    end

    assign bus.PULSE = pulse_q;
    assign bus.BUSY  = busy_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_count
        assign bus.COUNT[g*WIDTH +: WIDTH] = cnt_q[g];
    end

endmodule

// File: tb/tb_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_timer_bank
// Directed, self-checking bench for timer_bank (4 channels, 21-bit counters,
// 8-bit prescaler). Inputs change #1 after each rising edge; outputs are
// checked at the same point, so "after edge n" maps directly to one step().
// -----------------------------------------------------------------------------
module tb_timer_bank;
    localparam int CH = 4;
    localparam int W  = 21;
    localparam int PW = 8;

    logic CLK = 1'b0;
    logic RST;
    logic CLR;
    int   tests = 0;
    int   fails = 0;

    timer_bank_if #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) bus ();

    timer_bank #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_limit(input int ch, input logic [W-1:0] v);
        bus.LIMIT[ch*W +: W] = v;
    endtask

    function automatic logic [W-1:0] cnt(input int ch);
        return bus.COUNT[ch*W +: W];
    endfunction

    initial begin
        RST = 1'b1;
        CLR = 1'b0;
        bus.PRESCALE = '0;
        bus.START    = '0;
        bus.STOP     = '0;
        bus.PERIODIC = '0;
        bus.LIMIT    = '0;
        step();
        step();
        RST = 1'b0;

        // Reset state
        chk("rst_busy",  {28'd0, bus.BUSY},  32'd0);
        chk("rst_pulse", {28'd0, bus.PULSE}, 32'd0);
        for (int i = 0; i < CH; i++) begin
            chk("rst_count", {11'd0, cnt(i)}, 32'd0);
        end

        // 1: one-shot, limit 3, prescale 0
        set_limit(0, 21'd3);
        bus.PERIODIC[0] = 1'b0;
        bus.START[0]    = 1'b1;
        step();                                   // edge t
        bus.START[0] = 1'b0;
        chk("t1_busy_t",  {31'd0, bus.BUSY[0]},  32'd1);
        chk("t1_cnt_t",   {11'd0, cnt(0)},       32'd0);
        step(); step(); step();                   // t+3
        chk("t1_busy_t3", {31'd0, bus.BUSY[0]},  32'd1);
        chk("t1_cnt_t3",  {11'd0, cnt(0)},       32'd3);
        chk("t1_pulse_t3",{31'd0, bus.PULSE[0]}, 32'd0);
        step();                                   // t+4
        chk("t1_pulse_t4",{31'd0, bus.PULSE[0]}, 32'd1);
        chk("t1_busy_t4", {31'd0, bus.BUSY[0]},  32'd0);
        chk("t1_cnt_t4",  {11'd0, cnt(0)},       32'd0);
        step();                                   // t+5
        chk("t1_pulse_t5",{31'd0, bus.PULSE[0]}, 32'd0);

        // 2: periodic, limit 2; STOP coincides with terminal count at t+9
        set_limit(1, 21'd2);
        bus.PERIODIC[1] = 1'b1;
        bus.START[1]    = 1'b1;
        step();                                   // edge t
        bus.START[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t2_pulse", {31'd0, bus.PULSE[1]}, (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("t2_busy",  {31'd0, bus.BUSY[1]},  32'd1);
        end
        bus.STOP[1] = 1'b1;
        step();                                   // t+9
        bus.STOP[1] = 1'b0;
        chk("t2_stop_pulse", {31'd0, bus.PULSE[1]}, 32'd0);
        chk("t2_stop_busy",  {31'd0, bus.BUSY[1]},  32'd0);

        // 3: CLR then prescale 1, limit 1 periodic -> pulses at c+4, c+8, c+12
        CLR = 1'b1;
        step();                                   // edge c
        CLR = 1'b0;
        chk("t3_clr_busy", {28'd0, bus.BUSY}, 32'd0);
        bus.PRESCALE    = 8'd1;
        set_limit(0, 21'd1);
        bus.PERIODIC[0] = 1'b1;
        bus.START[0]    = 1'b1;
        step();                                   // c+1
        bus.START[0] = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            step();
            chk("t3_pulse", {31'd0, bus.PULSE[0]},
                (k == 4 || k == 8 || k == 12) ? 32'd1 : 32'd0);
        end
        bus.STOP[0] = 1'b1;
        step();
        bus.STOP[0] = 1'b0;
        chk("t3_stop_busy", {31'd0, bus.BUSY[0]}, 32'd0);

        // 4: two channels started together; ch0 LIMIT change ignored
        bus.PRESCALE = 8'd0;
        set_limit(0, 21'd5);
        set_limit(1, 21'd1);
        bus.PERIODIC = '0;
        bus.START    = 4'b0011;
        step();                                   // edge t
        bus.START = '0;
        set_limit(0, 21'd2);
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t4_pulse0", {31'd0, bus.PULSE[0]}, (k == 6) ? 32'd1 : 32'd0);
            chk("t4_pulse1", {31'd0, bus.PULSE[1]}, (k == 2) ? 32'd1 : 32'd0);
        end
        chk("t4_busy", {28'd0, bus.BUSY}, 32'd0);

        // 5: ch2 restart with a shorter limit
        set_limit(2, 21'd4);
        bus.START[2] = 1'b1;
        step();                                   // t
        bus.START[2] = 1'b0;
        step();                                   // t+1
        set_limit(2, 21'd1);
        bus.START[2] = 1'b1;
        step();                                   // t+2
        bus.START[2] = 1'b0;
        chk("t5_cnt_restart", {11'd0, cnt(2)}, 32'd0);
        for (int k = 3; k <= 6; k++) begin
            step();
            chk("t5_pulse", {31'd0, bus.PULSE[2]}, (k == 4) ? 32'd1 : 32'd0);
        end
        bus.START[2] = 1'b1;
        bus.STOP[2]  = 1'b1;
        step();
        bus.START[2] = 1'b0;
        bus.STOP[2]  = 1'b0;
        chk("t5_stopstart_busy", {31'd0, bus.BUSY[2]}, 32'd0);
        step();
        chk("t5_stopstart_busy2", {31'd0, bus.BUSY[2]}, 32'd0);

        // 6: RST one cycle before terminal count, then restart with limit 0
        set_limit(3, 21'd7);
        bus.START[3] = 1'b1;
        step();                                   // t
        bus.START[3] = 1'b0;
        for (int k = 1; k <= 6; k++) step();      // t+6
        chk("t6_cnt_t6",  {11'd0, cnt(3)},      32'd6);
        chk("t6_busy_t6", {31'd0, bus.BUSY[3]}, 32'd1);
        RST = 1'b1;
        step();                                   // t+7
        RST = 1'b0;
        chk("t6_rst_pulse", {28'd0, bus.PULSE}, 32'd0);
        chk("t6_rst_busy",  {28'd0, bus.BUSY},  32'd0);
        chk("t6_rst_cnt",   {11'd0, cnt(3)},    32'd0);
        set_limit(3, 21'd0);
        bus.START[3] = 1'b1;
        step();                                   // t+8
        bus.START[3] = 1'b0;
        chk("t6_busy_t8",  {31'd0, bus.BUSY[3]},  32'd1);
        chk("t6_pulse_t8", {28'd0, bus.PULSE},    32'd0);
        step();                                   // t+9
        chk("t6_pulse_t9", {31'd0, bus.PULSE[3]}, 32'd1);
        chk("t6_busy_t9",  {31'd0, bus.BUSY[3]},  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
